// File: rtl/usb_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_pkg : shared types and line constants for the USB FS TX path   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    STUFF   = 3'd3,
    EOP_SE0 = 3'd4,
    EOP_J   = 3'd5
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam int         EOP_SE0_BITS = 2;

  // {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage
`default_nettype wire

// File: rtl/usb_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_bit_timer : divides clk into USB bit times, strobe on last clk    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_strobe
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_strobe = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_encoder : USB FS transmit path - SYNC, stuffing, NRZI, EOP     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [2:0] EOP_LAST = 3'(EOP_SE0_BITS - 1);

  tx_state_t  state, state_nx;
  logic [7:0] shreg, shreg_nx;
  logic [2:0] idx, idx_nx;
  logic [2:0] ones, ones_nx;
  logic       level, level_nx;      // NRZI level, 1 = J
  logic       last_byte, last_nx;
  logic [1:0] line, line_nx;
  logic       active, active_nx;
  logic       done, done_nx;
  logic       bit_strobe, start;
  logic       need_byte, send, send_bit;

  assign start = (state == IDLE) && tx_valid;

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .bit_strobe (bit_strobe)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      ones      <= '0;
      level     <= 1'b1;
      last_byte <= 1'b0;
      line      <= LINE_J;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      idx       <= idx_nx;
      ones      <= ones_nx;
      level     <= level_nx;
      last_byte <= last_nx;
      line      <= line_nx;
      active    <= active_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    idx_nx    = idx;
    ones_nx   = ones;
    level_nx  = level;
    last_nx   = last_byte;
    line_nx   = line;
    active_nx = active;
    done_nx   = 1'b0;
    tx_ready  = 1'b0;
    tx_err    = 1'b0;
    need_byte = 1'b0;
    send      = 1'b0;
    send_bit  = 1'b0;

    case (state)
      IDLE: begin
        line_nx  = LINE_J;
        level_nx = 1'b1;
        ones_nx  = '0;
        if (tx_valid) begin
          state_nx  = SYNC;
          active_nx = 1'b1;
          send      = 1'b1;
          send_bit  = SYNC_BYTE[0];
          shreg_nx  = {1'b0, SYNC_BYTE[7:1]};
          idx_nx    = 3'd1;
          last_nx   = 1'b0;
        end
      end
      SYNC: if (bit_strobe) begin
        if (idx != 3'd0) begin
          send     = 1'b1;
          send_bit = shreg[0];
          shreg_nx = shreg >> 1;
          idx_nx   = idx + 3'd1;
        end else begin
          need_byte = 1'b1;
        end
      end
      DATA, STUFF: if (bit_strobe) begin
        // stuff check precedes the byte boundary so a trailing sixth 1 still gets its stuff bit
        if (state == DATA && ones == STUFF_LIMIT) begin
          state_nx = STUFF;
          send     = 1'b1;
          send_bit = 1'b0;
        end else if (idx != 3'd0) begin
          state_nx = DATA;
          send     = 1'b1;
          send_bit = shreg[0];
          shreg_nx = shreg >> 1;
          idx_nx   = idx + 3'd1;
        end else begin
          need_byte = 1'b1;
        end
      end
      EOP_SE0: if (bit_strobe) begin
        if (idx == EOP_LAST) begin
          state_nx = EOP_J;
          line_nx  = LINE_J;
          level_nx = 1'b1;
        end else begin
          idx_nx = idx + 3'd1;
        end
      end
      EOP_J: if (bit_strobe) begin
        state_nx  = IDLE;
        active_nx = 1'b0;
        done_nx   = 1'b1;
        ones_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase

    if (need_byte) begin
      if (!last_byte && tx_valid) begin
        tx_ready = 1'b1;
        state_nx = DATA;
        send     = 1'b1;
        send_bit = tx_data[0];
        shreg_nx = {1'b0, tx_data[7:1]};
        idx_nx   = 3'd1;
        last_nx  = tx_last;
      end else begin
        tx_err   = !last_byte;
        state_nx = EOP_SE0;
        line_nx  = LINE_SE0;
        idx_nx   = '0;
      end
    end

    if (send) begin
      level_nx = send_bit ? level : ~level;
      ones_nx  = send_bit ? ones + 3'd1 : 3'd0;
      line_nx  = level_nx ? LINE_J : LINE_K;
    end
  end

  assign d_plus    = line[1];
  assign d_minus   = line[0];
  assign tx_active = active;
  assign tx_done   = done;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_usb_tx_encoder : packet-level model vs. DUT, cycle-by-cycle compare |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_usb_tx_encoder;

  localparam int         CPB      = 8;
  localparam int         MAXC     = 1024;
  localparam logic [1:0] LJ       = 2'b10;
  localparam logic [1:0] LK       = 2'b01;
  localparam logic [1:0] LSE0     = 2'b00;
  localparam logic [5:0] IDLE_OUT = 6'b100000;  // {dp,dm,active,ready,done,err}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, d_plus, d_minus, tx_active, tx_done, tx_err;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // packet description and model products
  logic [7:0] pkt[$];
  bit         pkt_complete;
  logic [1:0] sym[$];
  logic [1:0] m_lvl;
  int         m_ones;
  int         ncyc;
  logic [7:0] s_data [MAXC];
  bit         s_valid[MAXC];
  bit         s_last [MAXC];
  logic [5:0] e_out  [MAXC];

  // observations of the DUT for packet-level checks
  int         ready_cyc[$];
  int         done_cyc;
  int         err_seen;
  logic [1:0] line_q[$];
  logic [7:0] dec[$];

  task automatic check_vec(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%s expected=%s", name, got, exp);
    end
  endtask

  function automatic logic [1:0] toggle(input logic [1:0] l);
    return (l == LJ) ? LK : LJ;
  endfunction

  // one logical bit onto the wire: NRZI, then a stuffed 0 after six 1s
  function automatic void push_bit(input logic b);
    if (!b) m_lvl = toggle(m_lvl);
    m_ones = b ? m_ones + 1 : 0;
    sym.push_back(m_lvl);
    if (m_ones == 6) begin
      m_lvl  = toggle(m_lvl);
      m_ones = 0;
      sym.push_back(m_lvl);
    end
  endfunction

  function automatic string sym_str();
    string s;
    s = "";
    foreach (sym[i]) s = {s, (sym[i] == LJ) ? "J" : (sym[i] == LK) ? "K" : "0"};
    return s;
  endfunction

  // Cycle 0 is the first cycle tx_valid is high in IDLE; symbol i occupies cycles 1+i*CPB..(i+1)*CPB.
  task automatic build_model(input int gap);
    int         rdy[$];
    int         err_cyc;
    int         n;
    int         first;
    logic [7:0] sb;
    logic [7:0] byt;
    sym.delete();
    m_lvl   = LJ;
    m_ones  = 0;
    err_cyc = -1;
    sb      = 8'h80;
    for (int i = 0; i < 8; i++) push_bit(sb[i]);
    foreach (pkt[k]) begin
      rdy.push_back(sym.size() * CPB);
      byt = pkt[k];
      for (int i = 0; i < 8; i++) push_bit(byt[i]);
    end
    if (!pkt_complete) err_cyc = sym.size() * CPB;
    sym.push_back(LSE0);
    sym.push_back(LSE0);
    sym.push_back(LJ);
    n    = sym.size();
    ncyc = n * CPB + 2 + gap;
    for (int c = 0; c < ncyc; c++) begin
      s_valid[c] = 1'b0;
      s_data[c]  = 8'h00;
      s_last[c]  = 1'b0;
      e_out[c]   = IDLE_OUT;
      if (c >= 1 && c <= n * CPB) e_out[c][5:3] = {sym[(c - 1) / CPB], 1'b1};
      e_out[c][1] = (c == n * CPB + 1);
      e_out[c][0] = (c == err_cyc);
    end
    foreach (pkt[k]) begin
      first = (k == 0) ? 0 : rdy[k - 1] + 1;
      for (int c = first; c <= rdy[k]; c++) begin
        s_valid[c] = 1'b1;
        s_data[c]  = pkt[k];
        s_last[c]  = pkt_complete && (k == pkt.size() - 1);
      end
      e_out[rdy[k]][2] = 1'b1;
    end
  endtask

  task automatic run(input string tag, input int abort_at);
    logic [5:0] got, exp;
    bit         aborted;
    ready_cyc.delete();
    line_q.delete();
    done_cyc = -1;
    err_seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      aborted = (abort_at >= 0) && (c > abort_at);
      rst     = (c == abort_at);
      tx_valid = aborted ? 1'b0 : s_valid[c];
      tx_data  = aborted ? 8'h00 : s_data[c];
      tx_last  = aborted ? 1'b0 : s_last[c];
      @(negedge clk);
      exp = aborted ? IDLE_OUT : e_out[c];
      got = {d_plus, d_minus, tx_active, tx_ready, tx_done, tx_err};
      check_vec($sformatf("%s cyc%0d", tag, c), got, exp);
      if (tx_ready) ready_cyc.push_back(c);
      if (tx_done) done_cyc = c;
      if (tx_err) err_seen++;
      if (c >= 1 && ((c - 1) % CPB) == CPB / 2 && tx_active) line_q.push_back({d_plus, d_minus});
    end
    rst = 1'b0;
  endtask

  // Undo NRZI and stuffing on the sampled line, drop SYNC, reassemble bytes LSB-first.
  function automatic void decode_line();
    logic [1:0] prev;
    int         ones, nb;
    bit         skip;
    logic [7:0] acc;
    logic       b;
    prev = LJ; ones = 0; nb = 0; skip = 1'b0; acc = 8'h00;
    dec.delete();
    foreach (line_q[i]) begin
      if (line_q[i] == LSE0) break;
      b    = (line_q[i] == prev);
      prev = line_q[i];
      if (skip) begin
        skip = 1'b0;
        ones = 0;
      end else begin
        ones = b ? ones + 1 : 0;
        skip = (ones == 6);
        if (nb >= 8) begin
          acc[(nb - 8) % 8] = b;
          if ((nb - 8) % 8 == 7) dec.push_back(acc);
        end
        nb++;
      end
    end
  endfunction

  initial begin
    int n;

    // reset held 3 clocks, then 50 idle clocks
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      check_vec($sformatf("reset cyc%0d", c), {d_plus, d_minus, tx_active, tx_ready, tx_done, tx_err}, IDLE_OUT);
    end
    pkt.delete(); pkt.push_back(8'h00); pkt_complete = 1'b1;
    build_model(0);
    ncyc = 50;
    for (int c = 0; c < ncyc; c++) begin s_valid[c] = 1'b0; e_out[c] = IDLE_OUT; end
    run("idle", -1);

    // single 0x00
    pkt.delete(); pkt.push_back(8'h00); pkt_complete = 1'b1;
    build_model(4);
    check_str("model_00", sym_str(), "KJKJKJKKJKJKJKJK00J");
    run("b00", -1);
    check_int("b00 ready_count", ready_cyc.size(), 1);
    if (ready_cyc.size() > 0) check_int("b00 ready_cycle", ready_cyc[0], 8 * CPB);
    check_int("b00 done_latency", done_cyc, 19 * CPB + 1);

    // single 0xFF: SYNC's final 1 counts toward the six
    pkt.delete(); pkt.push_back(8'hFF); pkt_complete = 1'b1;
    build_model(3);
    check_str("model_ff", sym_str(), "KJKJKJKKKKKKKJJJJ00J");
    run("bff", -1);
    check_int("bff ready_count", ready_cyc.size(), 1);
    check_int("bff done_latency", done_cyc, 20 * CPB + 1);

    // 3F then A5 back-to-back
    pkt.delete(); pkt.push_back(8'h3F); pkt.push_back(8'hA5); pkt_complete = 1'b1;
    build_model(5);
    run("b3fa5", -1);
    check_int("b3fa5 ready_count", ready_cyc.size(), 2);
    // the stuff bit inside 0x3F stretches the byte to nine bit times
    if (ready_cyc.size() == 2) check_int("b3fa5 ready_spacing", ready_cyc[1] - ready_cyc[0], 9 * CPB);
    decode_line();
    check_int("b3fa5 decoded_count", dec.size(), 2);
    if (dec.size() == 2) begin
      check_int("b3fa5 byte0", int'(dec[0]), 8'h3F);
      check_int("b3fa5 byte1", int'(dec[1]), 8'hA5);
    end

    // underrun after 0x12
    pkt.delete(); pkt.push_back(8'h12); pkt_complete = 1'b0;
    build_model(4);
    run("under", -1);
    check_int("under err_count", err_seen, 1);
    check_int("under done_latency", done_cyc, 19 * CPB + 1);

    // reset in the middle of data bit 4, then a clean packet
    pkt.delete(); pkt.push_back(8'h55); pkt_complete = 1'b1;
    build_model(6);
    run("abort", 1 + 12 * CPB + 2);
    check_int("abort no_done", done_cyc, -1);
    pkt.delete(); pkt.push_back(8'h00); pkt_complete = 1'b1;
    build_model(3);
    run("post_abort", -1);
    check_int("post_abort done_latency", done_cyc, 19 * CPB + 1);

    // randomized packets, some truncated by underrun
    for (int p = 0; p < 12; p++) begin
      n = $urandom_range(1, 4);
      pkt.delete();
      for (int k = 0; k < n; k++) pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      pkt_complete = ($urandom_range(0, 4) != 0);
      build_model($urandom_range(1, 6));
      run($sformatf("rnd%0d", p), -1);
      check_int($sformatf("rnd%0d ready_count", p), ready_cyc.size(), n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
